// File: rtl/cordic_act_pkg.sv
// Shared constants and state encoding for the CORDIC activation stages.
package cordic_act_pkg;

    localparam int unsigned EXP_W_DEF = 10;
    localparam int unsigned OUT_W_DEF = 8;
    localparam int unsigned Q_W_DEF   = 9;

    localparam int unsigned ONE_Q6    = 64;
    localparam int unsigned DIVIDEND  = 16384;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cordic_sigmoid_div_8bit_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract den if it fits.
module restoring_div_step #(
    parameter int unsigned W = 11
) (
    input  logic [W-1:0] rem_in,
    input  logic         d_bit,
    input  logic [W-1:0] den,
    output logic [W-1:0] rem_out,
    output logic         q_bit
);

    logic [W:0] trial;

    always_comb begin
        trial   = {rem_in, d_bit};
        q_bit   = 1'b0;
        rem_out = trial[W-1:0];
        if (trial >= {1'b0, den}) begin
            q_bit   = 1'b1;
            rem_out = W'(trial - {1'b0, den});
        end
    end

endmodule

// File: rtl/cordic_sigmoid_div_8bit.sv
// Logistic sigmoid from e^(-|x|): y = 1/(1+e) via a 9-step restoring divider.
module cordic_sigmoid_div_8bit
    import cordic_act_pkg::*;
#(
    parameter int unsigned EXP_W = EXP_W_DEF,
    parameter int unsigned OUT_W = OUT_W_DEF,
    parameter int unsigned Q_W   = Q_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EXP_W-1:0] exp_in,
    input  logic             in_neg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] y_out
);

    localparam int unsigned DEN_W = EXP_W + 1;
    localparam int unsigned DVD_W = $clog2(DIVIDEND) + 1;
    localparam int unsigned CNT_W = $clog2(Q_W);

    state_t             state;
    logic [DEN_W-1:0]   den;
    logic [DEN_W-1:0]   rem;
    logic [DEN_W-1:0]   rem_in;
    logic [DEN_W-1:0]   rem_next;
    logic [DVD_W-1:0]   divd;
    logic [CNT_W-1:0]   cnt;
    logic [Q_W-2:0]     quo;
    logic [Q_W-1:0]     q_full;
    logic [Q_W:0]       mirror;
    logic [OUT_W-1:0]   y_res;
    logic               neg;
    logic               d_bit;
    logic               q_bit;

    assign in_ready = (state == IDLE);

    // den >= 64 means the dividend bits above the quotient window can never
    // yield a 1, so the first step folds them straight into the remainder.
    always_comb begin
        rem_in = rem;
        if (cnt == CNT_W'(Q_W - 1)) begin
            rem_in = DEN_W'(divd >> Q_W);
        end
        d_bit = divd[cnt];
    end

    restoring_div_step #(.W(DEN_W)) u_step (
        .rem_in  (rem_in),
        .d_bit   (d_bit),
        .den     (den),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

    always_comb begin
        q_full = {quo, q_bit};
        mirror = (Q_W + 1)'(1 << OUT_W) - {1'b0, q_full};
        if (neg) begin
            y_res = mirror[OUT_W-1:0];
        end else if (q_full > Q_W'((1 << OUT_W) - 1)) begin
            y_res = '1;
        end else begin
            y_res = q_full[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            y_out     <= '0;
            cnt       <= '0;
            rem       <= '0;
            den       <= '0;
            neg       <= 1'b0;
            divd      <= '0;
            quo       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        den   <= DEN_W'(ONE_Q6) + DEN_W'(exp_in);
                        neg   <= in_neg;
                        rem   <= '0;
                        divd  <= DVD_W'(DIVIDEND);
                        cnt   <= CNT_W'(Q_W - 1);
                        quo   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    rem <= rem_next;
                    quo <= q_full[Q_W-2:0];
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        y_out     <= y_res;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_sigmoid_div_8bit.sv
// Self-checking bench: directed literals plus a floor(16384/(64+e)) scoreboard.
module tb_cordic_sigmoid_div_8bit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] exp_in;
    logic       in_neg;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y_out;

    int total = 0;
    int bad   = 0;
    int n_acc = 0;
    int n_out = 0;
    int q_exp[$];
    bit rand_rdy = 1'b0;

    cordic_sigmoid_div_8bit #(.EXP_W(10), .OUT_W(8), .Q_W(9)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .exp_in    (exp_in),
        .in_neg    (in_neg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_out     (y_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic int model(input int e, input bit n);
        int q;
        q = 16384 / (64 + e);
        if (n) return 256 - q;
        return (q > 255) ? 255 : q;
    endfunction

    // Scoreboard: inputs and outputs sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            n_acc -= q_exp.size();
            q_exp.delete();
        end else begin
            check("ready_valid_excl", int'(in_ready && out_valid), 0);
            if (in_valid && in_ready) begin
                q_exp.push_back(model(int'(exp_in), in_neg));
                n_acc++;
            end
            if (out_valid) begin
                if (q_exp.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    check("y_model", int'(y_out), q_exp[0]);
                    if (out_ready) begin
                        void'(q_exp.pop_front());
                        n_out++;
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input int e, input bit n);
        int k;
        exp_in   = 10'(e);
        in_neg   = n;
        in_valid = 1'b1;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (k == 200) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic directed(input int e, input bit n, input int lit, input bit chk_lat);
        int cyc;
        send(e, n);
        wait_out(cyc);
        if (!out_valid) begin
            check("out_timeout", 0, 1);
        end else begin
            check($sformatf("lit_e%0d_n%0d", e, n), int'(y_out), lit);
            if (chk_lat) check("latency", cyc, 9);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int y_hold;
        int cyc;
        int out0;
        int k;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_neg    = 1'b0;
        exp_in    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_y_out", int'(y_out), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        directed(64, 0, 128, 1'b1);
        directed(0, 0, 255, 1'b0);
        directed(0, 1, 0, 1'b0);
        directed(192, 0, 64, 1'b0);
        directed(192, 1, 192, 1'b0);
        directed(1023, 0, 15, 1'b0);
        directed(1023, 1, 241, 1'b0);

        // Backpressure with an ignored in_valid while DONE.
        out_ready = 1'b0;
        send(100, 0);
        wait_out(cyc);
        check("bp_lit", int'(y_out), 99);
        y_hold = int'(y_out);
        for (int i = 0; i < 20; i++) begin
            if (i == 2) begin
                exp_in   = 10'd5;
                in_valid = 1'b1;
            end
            @(posedge clk);
            #1;
            check("bp_hold", int'(y_out), y_hold);
            check("bp_valid", int'(out_valid), 1);
            check("bp_in_ready", int'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release", int'(out_valid), 0);
        check("bp_queue_empty", q_exp.size(), 0);
        check("bp_acc_vs_out", n_acc, n_out);

        // Reset during BUSY step 4.
        send(64, 0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_in_ready", int'(in_ready), 1);
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_y_out", int'(y_out), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        directed(64, 0, 128, 1'b1);

        // Full sweep under random downstream backpressure.
        out0     = n_out;
        rand_rdy = 1'b1;
        for (int e = 0; e < 1024; e++) begin
            for (int n = 0; n < 2; n++) begin
                send(e, 1'(n));
            end
        end
        for (k = 0; k < 400; k++) begin
            if (q_exp.size() == 0 && !out_valid) break;
            @(posedge clk);
            #1;
        end
        if (k == 400) check("drain_timeout", 0, 1);
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        check("sweep_count", n_out - out0, 2048);
        check("sweep_left", q_exp.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
